// File: rtl/turbo_deinterleaver_if.sv
// Byte-stream handshake bundle for turbo_deinterleaver: block-side inputs and outputs,
// with master (stimulus/upstream) and slave (deinterleaver) views.
interface turbo_deinterleaver_if;
    logic       vld_in;
    logic       cbs;
    logic [7:0] data_in;
    logic       rdy_out;
    logic       rdy_in;
    logic       vld_out;
    logic [7:0] data_out;

    modport master (output vld_in, cbs, data_in, rdy_out,
                    input  rdy_in, vld_out, data_out);
    modport slave  (input  vld_in, cbs, data_in, rdy_out,
                    output rdy_in, vld_out, data_out);
endinterface

// File: rtl/turbo_deinterleaver.sv
// LTE QPP turbo de-interleaver: load K bits, scatter out[pi(i)] = in[i], stream bytes out.
// Define TURBO_DEINT_LARGE_EN to add K=6144 (cbs=1); otherwise only K=1056 is built.
module turbo_deinterleaver (
    input  logic                    clk,
    input  logic                    reset,
    turbo_deinterleaver_if.slave    bus
);
    localparam int          K_SMALL = 1056;
    localparam int          K_LARGE = 6144;
    localparam logic [12:0] F1_S    = 13'd17;
    localparam logic [12:0] F2_S    = 13'd66;
`ifdef TURBO_DEINT_LARGE_EN
    localparam int          KMAX    = K_LARGE;
    localparam logic [12:0] F1_L    = 13'd263;
    localparam logic [12:0] F2_L    = 13'd480;
`else
    localparam int          KMAX    = K_SMALL;
`endif
    localparam int          IW      = $clog2(KMAX);

    typedef enum logic [1:0] {IDLE, LOAD, PERM, SEND} state_t;

    state_t            state_q, state_d;
    logic [9:0]        n_q, n_d, m_q, m_d;
    logic [12:0]       i_q, i_d, pi_q, pi_d, g_q, g_d;
    logic [KMAX-1:0]   inbuf_q, inbuf_d, outbuf_q, outbuf_d;
    logic              rdy_q, rdy_d, vld_q, vld_d;
    logic [7:0]        dout_q, dout_d;
    logic [12:0]       k_w, g0_w, step_w, nb, mb;
    logic [9:0]        last_byte_w;

`ifdef TURBO_DEINT_LARGE_EN
    logic              large_q, large_d;
`else
    logic              unused_cbs;
    assign unused_cbs = bus.cbs;
`endif

    // One compare-and-subtract keeps a+b in [0,K) since both operands already are.
    function automatic logic [12:0] mod_add(input logic [12:0] a, input logic [12:0] b,
                                            input logic [12:0] k);
        logic [13:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, k}) s = s - {1'b0, k};
        return s[12:0];
    endfunction

    always_comb begin
        k_w         = 13'(K_SMALL);
        g0_w        = F1_S + F2_S;
        step_w      = F2_S << 1;
        last_byte_w = 10'(K_SMALL / 8 - 1);
`ifdef TURBO_DEINT_LARGE_EN
        if (large_q) begin
            k_w         = 13'(K_LARGE);
            g0_w        = F1_L + F2_L;
            step_w      = F2_L << 1;
            last_byte_w = 10'(K_LARGE / 8 - 1);
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        m_d      = m_q;
        i_d      = i_q;
        pi_d     = pi_q;
        g_d      = g_q;
        inbuf_d  = inbuf_q;
        outbuf_d = outbuf_q;
        rdy_d    = rdy_q;
        vld_d    = vld_q;
        dout_d   = dout_q;
`ifdef TURBO_DEINT_LARGE_EN
        large_d  = large_q;
`endif
        nb       = {n_q, 3'b000};
        mb       = {m_q + 10'd1, 3'b000};
        case (state_q)
            IDLE: begin
                rdy_d = 1'b1;
                // rdy_q gates the header so the first cycle out of reset never accepts one
                if (rdy_q && bus.vld_in) begin
                    state_d = LOAD;
                    rdy_d   = 1'b0;
                    n_d     = '0;
`ifdef TURBO_DEINT_LARGE_EN
                    large_d = bus.cbs;
`endif
                end
            end
            LOAD: begin
                if (bus.vld_in) begin
                    inbuf_d[nb[IW-1:0] +: 8] = bus.data_in;
                    if (n_q == last_byte_w) begin
                        state_d = PERM;
                        i_d     = '0;
                        pi_d    = '0;
                        g_d     = g0_w;
                    end else begin
                        n_d = n_q + 10'd1;
                    end
                end
            end
            PERM: begin
                outbuf_d[pi_q[IW-1:0]] = inbuf_q[i_q[IW-1:0]];
                pi_d = mod_add(pi_q, g_q, k_w);
                g_d  = mod_add(g_q, step_w, k_w);
                i_d  = i_q + 13'd1;
                if (i_q == k_w - 13'd1) begin
                    // byte 0 may include the bit written this very cycle
                    state_d = SEND;
                    m_d     = '0;
                    vld_d   = 1'b1;
                    dout_d  = outbuf_d[7:0];
                end
            end
            SEND: begin
                if (bus.rdy_out) begin
                    if (m_q == last_byte_w) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                        dout_d  = '0;
                        rdy_d   = 1'b1;
                    end else begin
                        m_d    = m_q + 10'd1;
                        dout_d = outbuf_q[mb[IW-1:0] +: 8];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        inbuf_q  <= inbuf_d;
        outbuf_q <= outbuf_d;
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            m_q     <= '0;
            i_q     <= '0;
            pi_q    <= '0;
            g_q     <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            dout_q  <= '0;
`ifdef TURBO_DEINT_LARGE_EN
            large_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            i_q     <= i_d;
            pi_q    <= pi_d;
            g_q     <= g_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
`ifdef TURBO_DEINT_LARGE_EN
            large_q <= large_d;
`endif
        end
    end

    assign bus.rdy_in   = rdy_q;
    assign bus.vld_out  = vld_q;
    assign bus.data_out = dout_q;
endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Bench for turbo_deinterleaver: directed table vectors plus random blocks checked
// against a direct-formula QPP model (pi(i) = (f1*i + f2*i*i) mod K).
module tb_turbo_deinterleaver;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    turbo_deinterleaver_if bus ();
    turbo_deinterleaver dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [7:0] in_b  [768];
    logic [7:0] exp_b [768];
    logic [7:0] orig  [768];
    logic [7:0] got_b [$];
    int         lat;

    typedef struct {
        int         in_idx;
        logic [7:0] in_val;
        int         out_idx;
        logic [7:0] out_val;
    } vec_t;
    vec_t vt [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int qpp(input int i, input int k);
        longint f1, f2;
        f1 = (k == 1056) ? 17 : 263;
        f2 = (k == 1056) ? 66 : 480;
        return int'((f1 * i + f2 * longint'(i) * i) % k);
    endfunction

    task automatic model(input int k);
        int p;
        for (int b = 0; b < k / 8; b++) exp_b[b] = 8'h00;
        for (int i = 0; i < k; i++) begin
            p = qpp(i, k);
            exp_b[p / 8][p % 8] = in_b[i / 8][i % 8];
        end
    endtask

    task automatic rand_in(input int k);
        for (int b = 0; b < k / 8; b++) in_b[b] = 8'($urandom);
    endtask

    task automatic clear_in();
        for (int b = 0; b < 768; b++) in_b[b] = 8'h00;
    endtask

    // rmode: 0 always ready, 1 ready 3 on / 3 off, 2 random. abort_after>=0 resets mid-load.
    task automatic run_block(input int k, input bit cbsv, input bit gaps, input int rmode,
                             input int abort_after);
        int         n, cyc, phase, hold_err;
        logic       r, v;
        logic [7:0] d;
        got_b.delete();
        hold_err = 0;
        cyc = 0;
        while (!bus.rdy_in && cyc < 200) begin tick(); cyc++; end
        if (!bus.rdy_in) begin check("rdy_in_wait", 0, 1); return; end
        bus.vld_in = 1'b1; bus.cbs = cbsv;
        tick();
        n = 0;
        while (n < k / 8) begin
            if (n == abort_after) begin
                bus.vld_in = 1'b0;
                reset = 1'b1; tick(); tick();
                reset = 1'b0;
                return;
            end
            if (gaps && $urandom_range(3) == 0) begin
                bus.vld_in = 1'b0; bus.data_in = 8'($urandom); bus.cbs = ~cbsv;
            end else begin
                bus.vld_in = 1'b1; bus.data_in = in_b[n]; n++;
            end
            tick();
        end
        bus.data_in = 8'h00;
        cyc = 1;
        bus.vld_in = gaps ? 1'($urandom_range(1)) : 1'b0;
        while (!bus.vld_out && cyc < k + 50) begin
            tick(); cyc++;
            bus.vld_in = gaps ? 1'($urandom_range(1)) : 1'b0;
        end
        bus.vld_in = 1'b0;
        lat = cyc;
        check("latency", lat, k + 1);
        phase = 0; cyc = 0;
        while (got_b.size() < k / 8 && cyc < 4 * k) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = (phase % 6) < 3;
                default: r = 1'($urandom_range(1));
            endcase
            phase++;
            bus.rdy_out = r;
            v = bus.vld_out; d = bus.data_out;
            if (v && r) got_b.push_back(d);
            tick(); cyc++;
            if (v && !r && (bus.vld_out !== 1'b1 || bus.data_out !== d)) hold_err++;
        end
        bus.rdy_out = 1'b0;
        check("byte_count", got_b.size(), k / 8);
        check("hold_under_backpressure", hold_err, 0);
        check("end_vld_out", bus.vld_out, 0);
        check("end_data_out", bus.data_out, 0);
        check("end_rdy_in", bus.rdy_in, 1);
    endtask

    task automatic compare_out(input string name, input int k);
        int bad;
        bad = 0;
        for (int b = 0; b < k / 8; b++)
            if (b >= got_b.size() || got_b[b] !== exp_b[b]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nz;
        vt[0] = '{0, 8'h02, 10, 8'h08};
        vt[1] = '{0, 8'h04, 37, 8'h04};
        vt[2] = '{0, 8'h01,  0, 8'h01};
        vt[3] = '{1, 8'h01, 17, 8'h01};

        reset = 1'b1;
        bus.vld_in = 1'b0; bus.cbs = 1'b0; bus.data_in = 8'h00; bus.rdy_out = 1'b0;
        tick(); tick(); tick();
        check("reset_rdy_in", bus.rdy_in, 0);
        check("reset_vld_out", bus.vld_out, 0);
        check("reset_data_out", bus.data_out, 0);
        reset = 1'b0;
        check("rdy_in_first_cycle", bus.rdy_in, 0);
        tick();
        check("rdy_in_second_cycle", bus.rdy_in, 1);
        check("idle_vld_out", bus.vld_out, 0);
        check("idle_data_out", bus.data_out, 0);

        // single-bit vectors: one input byte set, one known output byte expected
        for (int v = 0; v < 4; v++) begin
            clear_in();
            in_b[vt[v].in_idx] = vt[v].in_val;
            run_block(1056, 1'b0, 1'b0, 0, -1);
            check($sformatf("vec%0d_byte", v),
                  (vt[v].out_idx < got_b.size()) ? got_b[vt[v].out_idx] : 8'hxx, vt[v].out_val);
            nz = 0;
            for (int b = 0; b < got_b.size(); b++)
                if (b != vt[v].out_idx && got_b[b] !== 8'h00) nz++;
            check($sformatf("vec%0d_others_zero", v), nz, 0);
        end

        // random blocks with input gaps, stray strobes and random backpressure
        for (int r = 0; r < 2; r++) begin
            rand_in(1056); model(1056);
            run_block(1056, 1'b0, 1'b1, 2, -1);
            compare_out($sformatf("random%0d", r), 1056);
        end

        // abort after 50 bytes, then a clean block must come out correct
        rand_in(1056);
        run_block(1056, 1'b0, 1'b0, 0, 50);
        check("abort_rdy_in", bus.rdy_in, 0);
        check("abort_vld_out", bus.vld_out, 0);
        rand_in(1056); model(1056);
        run_block(1056, 1'b0, 1'b0, 0, -1);
        compare_out("after_abort", 1056);

        // round trip: interleave c'_i = c_pi(i), de-interleave, expect the original
        for (int b = 0; b < 132; b++) orig[b] = 8'($urandom);
        for (int i = 0; i < 1056; i++) begin
            int p;
            p = qpp(i, 1056);
            in_b[i / 8][i % 8] = orig[p / 8][p % 8];
        end
        for (int b = 0; b < 132; b++) exp_b[b] = orig[b];
        run_block(1056, 1'b0, 1'b0, 1, -1);
        compare_out("round_trip", 1056);

`ifdef TURBO_DEINT_LARGE_EN
        clear_in();
        in_b[0] = 8'h02;
        run_block(6144, 1'b1, 1'b0, 0, -1);
        check("large_byte92", (92 < got_b.size()) ? got_b[92] : 8'hxx, 8'h80);
        nz = 0;
        for (int b = 0; b < got_b.size(); b++)
            if (b != 92 && got_b[b] !== 8'h00) nz++;
        check("large_others_zero", nz, 0);
        rand_in(6144); model(6144);
        run_block(6144, 1'b1, 1'b1, 2, -1);
        compare_out("large_random", 6144);
        rand_in(1056); model(1056);
        run_block(1056, 1'b0, 1'b0, 0, -1);
        compare_out("small_after_large", 1056);
`else
        // cbs=1 on the header must still give a 1056-bit block
        rand_in(1056); model(1056);
        run_block(1056, 1'b1, 1'b0, 0, -1);
        compare_out("cbs_ignored", 1056);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
